// File: rtl/i2c_cfg_slave_pkg.sv
// Shared definitions for the I2C configuration slave and the level-1b glue block:
// config register layout, register pointer indices and slave FSM encodings.
package i2c_cfg_slave_pkg;

  // Layout of the map/clock-control register as seen by the glue block.
  typedef struct packed {
    logic       map_rom;
    logic       map_ram;
    logic       clk_hs;
    logic [2:0] clk_div;
  } map_cc_t;

  localparam int MAP_CC_DATA_SZ = $bits(map_cc_t);

  localparam logic [MAP_CC_DATA_SZ-1:0] CFG_RESET_VAL = 6'b010000;
  localparam logic [7:0]                ID_VAL        = 8'hB1;

  localparam logic [1:0] REG_CFG     = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_ID      = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_filter_m.sv
// Synchroniser plus glitch filter for one I2C line; emits the filtered level and
// one-cycle rise/fall pulses aligned with the filtered level changing.
module i2c_line_filter_m #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3
) (
  input  logic clkin,
  input  logic reset,
  input  logic line_ip,
  output logic line_op,
  output logic rise_op,
  output logic fall_op
);

  localparam int CW = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CW-1:0]          cnt_q;
  logic                   smp;

  assign smp = sync_p0[SYNC_STAGES-1];

  // Idle bus is high, so the filter comes out of reset believing the line is released.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_p0 <= '1;
      line_op <= 1'b1;
      cnt_q   <= '0;
      rise_op <= 1'b0;
      fall_op <= 1'b0;
    end else begin
      sync_p0[0] <= line_ip;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      rise_op <= 1'b0;
      fall_op <= 1'b0;
      if (smp == line_op) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_CNT - 1)) begin
        line_op <= smp;
        cnt_q   <= '0;
        rise_op <= smp;
        fall_op <= !smp;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_cfg_slave_m.sv
// I2C slave giving an external controller read/write access to the CPLD map and
// clock-control register, a scratch byte, the glue status byte and an ID byte.
module i2c_cfg_slave_m #(
  parameter logic [6:0] I2C_ADDR       = 7'h3A,
  parameter int         SYNC_STAGES    = 2,
  parameter int         FILT_CNT       = 3,
  parameter int         MAP_CC_DATA_SZ = i2c_cfg_slave_pkg::MAP_CC_DATA_SZ,
  parameter logic [MAP_CC_DATA_SZ-1:0] CFG_RESET_VAL = i2c_cfg_slave_pkg::CFG_RESET_VAL,
  parameter logic [7:0] ID_VAL         = i2c_cfg_slave_pkg::ID_VAL
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic                      scl_ip,
  input  logic                      sda_ip,
  output logic                      sda_oe_op,
  input  logic [7:0]                status_ip,
  output logic [MAP_CC_DATA_SZ-1:0] cfg_data_op,
  output logic                      cfg_wr_op,
  output logic                      busy_op
);

  import i2c_cfg_slave_pkg::*;

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter_m #(.SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT)) u_scl_filt (
    .clkin   (clkin),
    .reset   (reset),
    .line_ip (scl_ip),
    .line_op (scl_f),
    .rise_op (scl_rise),
    .fall_op (scl_fall)
  );

  i2c_line_filter_m #(.SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT)) u_sda_filt (
    .clkin   (clkin),
    .reset   (reset),
    .line_ip (sda_ip),
    .line_op (sda_f),
    .rise_op (sda_rise),
    .fall_op (sda_fall)
  );

  i2c_state_t state_q;
  logic [7:0] shift_q;
  logic [7:0] scratch_q;
  logic [7:0] nxt_byte;
  logic [2:0] bit_cnt_q;
  logic [1:0] ptr_q;
  logic       rw_q;
  logic       wr_pend_q;
  logic       start_det;
  logic       stop_det;

  // An scl edge in the same cycle makes an sda edge ordinary data, not a bus condition.
  assign start_det = sda_fall && scl_f && !scl_rise && !scl_fall;
  assign stop_det  = sda_rise && scl_f && !scl_rise && !scl_fall;
  assign nxt_byte  = {shift_q[6:0], sda_f};

  function automatic logic [7:0] rd_byte(input logic [1:0] p);
    case (p)
      REG_CFG:    rd_byte = 8'(cfg_data_op);
      REG_STATUS: rd_byte = status_ip;
      REG_ID:     rd_byte = ID_VAL;
      default:    rd_byte = scratch_q;
    endcase
  endfunction

  always_ff @(posedge clkin) begin
    cfg_wr_op <= 1'b0;
    if (reset) begin
      state_q     <= ST_IDLE;
      sda_oe_op   <= 1'b0;
      cfg_data_op <= CFG_RESET_VAL;
      busy_op     <= 1'b0;
      ptr_q       <= 2'd0;
      bit_cnt_q   <= 3'd0;
      rw_q        <= 1'b0;
      wr_pend_q   <= 1'b0;
      scratch_q   <= 8'd0;
    end else begin
      // Commit lands one cycle after the 8th data sample, once shift_q holds the byte.
      if (wr_pend_q) begin
        wr_pend_q <= 1'b0;
        ptr_q     <= ptr_q + 2'd1;
        case (ptr_q)
          REG_CFG: begin
            cfg_data_op <= shift_q[MAP_CC_DATA_SZ-1:0];
            cfg_wr_op   <= 1'b1;
          end
          REG_SCRATCH: scratch_q <= shift_q;
          default: ;
        endcase
      end

      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= 3'd0;
        sda_oe_op <= 1'b0;
        busy_op   <= 1'b0;
      end else if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        sda_oe_op <= 1'b0;
        busy_op   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_IGNORE: ;

          ST_ADDR: if (scl_rise) begin
            shift_q   <= nxt_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= 3'd0;
              if (nxt_byte[7:1] == I2C_ADDR) begin
                state_q <= ST_ADDR_ACK;
                busy_op <= 1'b1;
                rw_q    <= nxt_byte[0];
                shift_q <= rd_byte(ptr_q);
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end

          // Ack states: first scl fall pulls sda low, the next one ends the ack bit.
          ST_ADDR_ACK: if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_op <= 1'b1;
              bit_cnt_q <= 3'd1;
            end else begin
              bit_cnt_q <= 3'd0;
              if (rw_q) begin
                sda_oe_op <= !shift_q[7];
                state_q   <= ST_RDATA;
              end else begin
                sda_oe_op <= 1'b0;
                state_q   <= ST_PTR;
              end
            end
          end

          ST_PTR: if (scl_rise) begin
            shift_q   <= nxt_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= 3'd0;
              ptr_q     <= nxt_byte[1:0];
              state_q   <= ST_PTR_ACK;
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_op <= 1'b1;
              bit_cnt_q <= 3'd1;
            end else begin
              sda_oe_op <= 1'b0;
              bit_cnt_q <= 3'd0;
              state_q   <= ST_WDATA;
            end
          end

          ST_WDATA: if (scl_rise) begin
            shift_q   <= nxt_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= 3'd0;
              wr_pend_q <= 1'b1;
              state_q   <= ST_WDATA_ACK;
            end
          end

          ST_RDATA: begin
            if (scl_fall) sda_oe_op <= !shift_q[7];
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= 3'd0;
                state_q   <= ST_RDATA_ACK;
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_fall && bit_cnt_q == 3'd0) begin
              sda_oe_op <= 1'b0;
              bit_cnt_q <= 3'd1;
            end else if (scl_rise && bit_cnt_q == 3'd1) begin
              bit_cnt_q <= 3'd0;
              if (!sda_f) begin
                ptr_q   <= ptr_q + 2'd1;
                shift_q <= rd_byte(ptr_q + 2'd1);
                state_q <= ST_RDATA;
              end else begin
                busy_op <= 1'b0;
                state_q <= ST_IGNORE;
              end
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cfg_slave_m.sv
// Directed bench for i2c_cfg_slave_m: a bit-banged I2C master feeds a scoreboard
// of expected acks, read bytes, register values and cfg_wr_op pulses.
module tb_i2c_cfg_slave_m;

  localparam int Q = 16;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] status_ip = 8'h5C;
  logic       sda_oe_op;
  logic [5:0] cfg_data_op;
  logic       cfg_wr_op;
  logic       busy_op;
  logic       sda_line;

  assign sda_line = m_sda & ~sda_oe_op;

  i2c_cfg_slave_m dut (
    .clkin       (clkin),
    .reset       (reset),
    .scl_ip      (m_scl),
    .sda_ip      (sda_line),
    .sda_oe_op   (sda_oe_op),
    .status_ip   (status_ip),
    .cfg_data_op (cfg_data_op),
    .cfg_wr_op   (cfg_wr_op),
    .busy_op     (busy_op)
  );

  always #5 clkin = ~clkin;

  int          n_checks = 0;
  int          n_errors = 0;
  int          oe_cnt   = 0;
  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  logic [31:0] obs_val_q[$];
  logic [31:0] exp_wr_q[$];

  always @(posedge clkin) if (sda_oe_op) oe_cnt <= oe_cnt + 1;

  // Monitor: pairs each observation with the oldest expectation, and checks every
  // cfg_wr_op pulse against the queued expected config value.
  always @(negedge clkin) begin
    string       nm;
    logic [31:0] o;
    logic [31:0] e;
    while (obs_val_q.size() > 0) begin
      o = obs_val_q.pop_front();
      n_checks++;
      if (exp_val_q.size() == 0) begin
        n_errors++;
        $display("FAIL extra_obs: got 0x%0h, want no observation", o);
      end else begin
        nm = exp_name_q.pop_front();
        e  = exp_val_q.pop_front();
        if (o !== e) begin
          n_errors++;
          $display("FAIL %s: got 0x%0h, want 0x%0h", nm, o, e);
        end
      end
    end
    if (cfg_wr_op) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL cfg_wr_unexpected: got pulse with data 0x%0h, want no pulse", cfg_data_op);
      end else begin
        e = exp_wr_q.pop_front();
        if (32'(cfg_data_op) !== e) begin
          n_errors++;
          $display("FAIL cfg_wr_data: got 0x%0h, want 0x%0h", cfg_data_op, e);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] v);
    exp_name_q.push_back(nm);
    exp_val_q.push_back(v);
  endtask

  task automatic push_obs(input logic [31:0] v);
    obs_val_q.push_back(v);
  endtask

  task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    push_exp(nm, exp_v);
    push_obs(act);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; ticks(Q);
    m_scl = 1'b1; ticks(2*Q);
    m_sda = 1'b0; ticks(2*Q);
    m_scl = 1'b0; ticks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; ticks(Q);
    m_scl = 1'b1; ticks(2*Q);
    m_sda = 1'b1; ticks(2*Q);
  endtask

  // Entered Q cycles into scl low; leaves Q cycles into the next scl low.
  task automatic send_bit(input logic b, input logic glitch, output logic s);
    m_sda = b; ticks(Q/2);
    if (glitch) begin m_scl = 1'b1; ticks(1); m_scl = 1'b0; end
    ticks(Q/2);
    m_scl = 1'b1; ticks(Q/2);
    if (glitch) begin m_scl = 1'b0; ticks(1); m_scl = 1'b1; end
    ticks(Q/2);
    s = sda_line;
    ticks(Q);
    m_scl = 1'b0; ticks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input logic glitch,
                            input string nm);
    logic s;
    push_exp(nm, 32'(exp_ack));
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
    send_bit(1'b1, glitch, s);
    push_obs(32'(s));
  endtask

  task automatic read_byte(input logic [7:0] exp_b, input logic ack, input string nm);
    logic [7:0] v;
    logic       s;
    push_exp(nm, 32'(exp_b));
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    send_bit(ack, 1'b0, s);
    push_obs(32'(v));
  endtask

  initial begin
    int  oe0;
    logic s;

    ticks(5);
    check_now("rst_sda_oe", 32'(sda_oe_op),   32'h0);
    check_now("rst_cfg",    32'(cfg_data_op), 32'h10);
    check_now("rst_cfg_wr", 32'(cfg_wr_op),   32'h0);
    check_now("rst_busy",   32'(busy_op),     32'h0);
    reset = 1'b0;
    ticks(10);

    // Wrong address: never acked, following bytes ignored.
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h76, 1'b1, 1'b0, "t3_addr_nack");
    write_byte(8'h00, 1'b1, 1'b0, "t3_byte1_ignored");
    write_byte(8'h2B, 1'b1, 1'b0, "t3_byte2_ignored");
    i2c_stop();
    check_now("t3_oe_never", 32'(oe_cnt - oe0), 32'h0);
    check_now("t3_cfg",      32'(cfg_data_op),  32'h10);
    check_now("t3_busy",     32'(busy_op),      32'h0);

    // Basic config write.
    exp_wr_q.push_back(32'h2B);
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t1_addr_ack");
    check_now("t1_busy_mid", 32'(busy_op), 32'h1);
    write_byte(8'h00, 1'b0, 1'b0, "t1_ptr_ack");
    write_byte(8'h2B, 1'b0, 1'b0, "t1_data_ack");
    i2c_stop();
    ticks(Q);
    check_now("t1_cfg",        32'(cfg_data_op),     32'h2B);
    check_now("t1_busy_after", 32'(busy_op),         32'h0);
    check_now("t1_wr_pending", 32'(exp_wr_q.size()), 32'h0);

    // Pointer write, repeated start, read status then ID.
    status_ip = 8'h5C;
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t2_addr_w_ack");
    write_byte(8'h01, 1'b0, 1'b0, "t2_ptr_ack");
    i2c_start();
    write_byte(8'h75, 1'b0, 1'b0, "t2_addr_r_ack");
    read_byte(8'h5C, 1'b0, "t2_rd_status");
    read_byte(8'hB1, 1'b1, "t2_rd_id");
    check_now("t2_oe_after_nack",   32'(sda_oe_op), 32'h0);
    check_now("t2_busy_after_nack", 32'(busy_op),   32'h0);
    i2c_stop();

    // Burst write from scratch wrapping through all registers.
    exp_wr_q.push_back(32'h15);
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t4_addr_ack");
    write_byte(8'h03, 1'b0, 1'b0, "t4_ptr_ack");
    write_byte(8'hAA, 1'b0, 1'b0, "t4_scratch_ack");
    write_byte(8'h55, 1'b0, 1'b0, "t4_cfg_ack");
    write_byte(8'h77, 1'b0, 1'b0, "t4_status_wr_ack");
    write_byte(8'h99, 1'b0, 1'b0, "t4_id_wr_ack");
    i2c_stop();
    check_now("t4_cfg",        32'(cfg_data_op),     32'h15);
    check_now("t4_wr_pending", 32'(exp_wr_q.size()), 32'h0);
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t4_rb_addr_w_ack");
    write_byte(8'h03, 1'b0, 1'b0, "t4_rb_ptr_ack");
    i2c_start();
    write_byte(8'h75, 1'b0, 1'b0, "t4_rb_addr_r_ack");
    read_byte(8'hAA, 1'b0, "t4_rd_scratch");
    read_byte(8'h15, 1'b0, "t4_rd_cfg");
    read_byte(8'h5C, 1'b1, "t4_rd_status_wrap");
    i2c_stop();

    // Partial byte then STOP: nothing committed, slave back to idle.
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t5_addr_ack");
    write_byte(8'h00, 1'b0, 1'b0, "t5_ptr_ack");
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, s);
    i2c_stop();
    check_now("t5_cfg_kept", 32'(cfg_data_op), 32'h15);
    check_now("t5_busy",     32'(busy_op),     32'h0);
    oe0 = oe_cnt;
    m_scl = 1'b0; ticks(Q);
    for (int i = 7; i >= 0; i--) send_bit(((8'h74 >> i) & 8'h1) != 0, 1'b0, s);
    send_bit(1'b1, 1'b0, s);
    m_scl = 1'b1; ticks(2*Q);
    check_now("t5_idle_no_ack", 32'(oe_cnt - oe0), 32'h0);

    // Single-cycle scl glitches in every phase must not add or lose bits.
    exp_wr_q.push_back(32'h21);
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b1, "t5g_addr_ack");
    write_byte(8'h00, 1'b0, 1'b1, "t5g_ptr_ack");
    write_byte(8'h21, 1'b0, 1'b1, "t5g_data_ack");
    i2c_stop();
    check_now("t5g_cfg",        32'(cfg_data_op),     32'h21);
    check_now("t5g_wr_pending", 32'(exp_wr_q.size()), 32'h0);

    // Reset while the slave is driving a 0 read bit.
    status_ip = 8'h00;
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t6_addr_w_ack");
    write_byte(8'h01, 1'b0, 1'b0, "t6_ptr_ack");
    i2c_start();
    write_byte(8'h75, 1'b0, 1'b0, "t6_addr_r_ack");
    check_now("t6_driving0", 32'(sda_oe_op), 32'h1);
    check_now("t6_busy_pre", 32'(busy_op),   32'h1);
    reset = 1'b1;
    ticks(1);
    check_now("t6_rst_oe",     32'(sda_oe_op),   32'h0);
    check_now("t6_rst_cfg",    32'(cfg_data_op), 32'h10);
    check_now("t6_rst_busy",   32'(busy_op),     32'h0);
    check_now("t6_rst_cfg_wr", 32'(cfg_wr_op),   32'h0);
    reset = 1'b0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    ticks(4*Q);

    // Slave usable again after the mid-transfer reset.
    exp_wr_q.push_back(32'h3F);
    i2c_start();
    write_byte(8'h74, 1'b0, 1'b0, "t7_addr_ack");
    write_byte(8'h00, 1'b0, 1'b0, "t7_ptr_ack");
    write_byte(8'hFF, 1'b0, 1'b0, "t7_data_ack");
    i2c_stop();
    check_now("t7_cfg",        32'(cfg_data_op),     32'h3F);
    check_now("t7_wr_pending", 32'(exp_wr_q.size()), 32'h0);
    check_now("exp_q_drained", 32'(exp_val_q.size() - obs_val_q.size()), 32'h0);

    ticks(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
